// File: rtl/ysyx_22040750_defs.sv
// Shared definitions for the core-local interruptor (CLINT).
// Register offsets relative to the region base, response FSM state encoding,
// and the offset decoder used by the top level.
package ysyx_22040750_defs;

  // Register offsets inside the CLINT region (8-byte aligned)
  localparam logic [31:0] CLINT_MSIP       = 32'h0000_0000;
  localparam logic [31:0] CLINT_MTIMECMP   = 32'h0000_4000;
  localparam logic [31:0] CLINT_MTIME      = 32'h0000_BFF8;

  // Byte-within-doubleword bits of the address are ignored by the decoder
  localparam logic [31:0] CLINT_ALIGN_MASK = 32'hFFFF_FFF8;

  // Response FSM encoding: a single bit is enough for the two phases
  localparam int CLINT_STATE_W = 1;
  localparam logic [CLINT_STATE_W-1:0] ST_IDLE = 1'b0;
  localparam logic [CLINT_STATE_W-1:0] ST_RESP = 1'b1;

  // Which register a request targets
  typedef enum logic [1:0] {
    REG_NONE     = 2'd0,
    REG_MSIP     = 2'd1,
    REG_MTIMECMP = 2'd2,
    REG_MTIME    = 2'd3
  } clint_reg_e;

  // Decode a region-relative offset. The msip slot only exists when the
  // software-interrupt feature is built in; otherwise it reads as unmapped.
  function automatic clint_reg_e clint_decode(input logic [31:0] offset,
                                              input logic        msip_en);
    logic [31:0] aligned;
    aligned = offset & CLINT_ALIGN_MASK;
    if (aligned == CLINT_MTIMECMP) begin
      clint_decode = REG_MTIMECMP;
    end else if (aligned == CLINT_MTIME) begin
      clint_decode = REG_MTIME;
    end else if ((aligned == CLINT_MSIP) && msip_en) begin
      clint_decode = REG_MSIP;
    end else begin
      clint_decode = REG_NONE;
    end
  endfunction

endpackage

// File: rtl/ysyx_22040750_clint_if.sv
// MMIO request/response bundle between the MEM-stage master and the CLINT.
// Request is accepted on req_valid & req_ready; the response is held until
// rsp_ready is seen with rsp_valid high.
interface ysyx_22040750_clint_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/ysyx_22040750_clint_tick.sv
// mtime prescaler: free-running counter 0..TICK_DIV-1 that emits a one-clock
// tick enable on its last count. With TICK_DIV=1 the counter stays at zero
// and the tick is asserted every clock.
module ysyx_22040750_clint_tick #(
  parameter int TICK_DIV = 1
) (
  input  logic I_sys_clk,
  input  logic I_rst_n,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign tick = (cnt_reg == CNT_MAX);

  // Wrap to zero on the tick, otherwise count up
  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    if (tick) begin
      cnt_next = '0;
    end
  end

  // Prescaler state, cleared by reset
  always_ff @(posedge I_sys_clk) begin
    if (!I_rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/ysyx_22040750_clint.sv
// Core-local interruptor: memory-mapped mtime / mtimecmp (and optionally
// msip) behind a valid/ready MMIO slave, driving the CSR file's timer
// interrupt input.
// Optional feature macro: YSYX_22040750_CLINT_MSIP_EN adds the msip register
// at offset 0x0000 and the O_msip output; without it 0x0000 is unmapped.
module ysyx_22040750_clint
  import ysyx_22040750_defs::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
  parameter int          TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                    I_sys_clk,
  input  logic                    I_rst_n,
  ysyx_22040750_clint_if.slave    bus,
  output logic                    O_mtip
`ifdef YSYX_22040750_CLINT_MSIP_EN
  ,
  output logic                    O_msip
`endif
);

`ifdef YSYX_22040750_CLINT_MSIP_EN
  localparam logic MSIP_EN = 1'b1;
`else
  localparam logic MSIP_EN = 1'b0;
`endif

  logic [CLINT_STATE_W-1:0] state_reg;
  logic [63:0]              mtime_reg;
  logic [63:0]              mtimecmp_reg;
  logic [63:0]              rsp_rdata_reg;
  logic                     rsp_err_reg;
  logic                     mtip_reg;
`ifdef YSYX_22040750_CLINT_MSIP_EN
  logic                     msip_reg;
`endif

  logic        tick;
  logic        accept;
  logic [31:0] offset;
  clint_reg_e  target;
  logic [63:0] wmask;
  logic [63:0] rd_val;
  logic [63:0] mtime_next;
  logic [63:0] mtimecmp_next;
  logic        wr_mtime;
  logic        wr_mtimecmp;

  ysyx_22040750_clint_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .I_sys_clk (I_sys_clk),
    .I_rst_n   (I_rst_n),
    .tick      (tick)
  );

  // ---------------- request decode ----------------
  assign offset = bus.req_addr - BASE_ADDR;
  assign target = clint_decode(offset, MSIP_EN);
  assign accept = (state_reg == ST_IDLE) && bus.req_valid;

  assign wr_mtime    = accept && bus.req_wen && (target == REG_MTIME);
  assign wr_mtimecmp = accept && bus.req_wen && (target == REG_MTIMECMP);

  // Expand the byte strobes into a bit mask for the read-modify-write merge
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{bus.req_wstrb[gi]}};
    end
  endgenerate

  assign mtime_next    = (mtime_reg    & ~wmask) | (bus.req_wdata & wmask);
  assign mtimecmp_next = (mtimecmp_reg & ~wmask) | (bus.req_wdata & wmask);

  // Read mux: current (pre-edge) register value of the addressed slot
  always_comb begin
    rd_val = '0;
    case (target)
      REG_MTIMECMP: rd_val = mtimecmp_reg;
      REG_MTIME:    rd_val = mtime_reg;
`ifdef YSYX_22040750_CLINT_MSIP_EN
      REG_MSIP:     rd_val = {63'b0, msip_reg};
`endif
      default:      rd_val = '0;
    endcase
  end

  // ---------------- timer registers ----------------
  // mtime: a bus write takes priority over the prescaler tick on the same edge
  always_ff @(posedge I_sys_clk) begin
    if (!I_rst_n) begin
      mtime_reg <= '0;
    end else if (wr_mtime) begin
      mtime_reg <= mtime_next;
    end else if (tick) begin
      mtime_reg <= mtime_reg + 64'd1;
    end
  end

  // mtimecmp: only changed by bus writes
  always_ff @(posedge I_sys_clk) begin
    if (!I_rst_n) begin
      mtimecmp_reg <= MTIMECMP_RST;
    end else if (wr_mtimecmp) begin
      mtimecmp_reg <= mtimecmp_next;
    end
  end

  // Timer interrupt is a registered level of the unsigned compare
  always_ff @(posedge I_sys_clk) begin
    if (!I_rst_n) begin
      mtip_reg <= 1'b0;
    end else begin
      mtip_reg <= (mtime_reg >= mtimecmp_reg);
    end
  end

`ifdef YSYX_22040750_CLINT_MSIP_EN
  // Software interrupt bit lives in byte lane 0
  always_ff @(posedge I_sys_clk) begin
    if (!I_rst_n) begin
      msip_reg <= 1'b0;
    end else if (accept && bus.req_wen && (target == REG_MSIP) && bus.req_wstrb[0]) begin
      msip_reg <= bus.req_wdata[0];
    end
  end

  assign O_msip = msip_reg;
`endif

  // ---------------- response FSM ----------------
  // IDLE accepts one request and latches its response; RESP holds it until consumed
  always_ff @(posedge I_sys_clk) begin
    if (!I_rst_n) begin
      state_reg     <= ST_IDLE;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.req_valid) begin
            state_reg     <= ST_RESP;
            rsp_err_reg   <= (target == REG_NONE);
            rsp_rdata_reg <= bus.req_wen ? 64'd0 : rd_val;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (state_reg == ST_IDLE);
  assign bus.rsp_valid = (state_reg == ST_RESP);
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign O_mtip        = mtip_reg;

endmodule

// File: tb/tb_ysyx_22040750_clint.sv
// Testbench for ysyx_22040750_clint: one instance with TICK_DIV=1 (A) and one
// with TICK_DIV=4 (B) share a request bus steered by 'sel'. A behavioural
// model tracks mtime as "edges since reset / TICK_DIV" plus bus writes.
module tb_ysyx_22040750_clint;

  localparam logic [31:0] BASE    = 32'h0200_0000;
  localparam logic [31:0] A_MSIP  = BASE;
  localparam logic [31:0] A_CMP   = BASE + 32'h4000;
  localparam logic [31:0] A_MTIME = BASE + 32'hBFF8;
  localparam int TDIV_A = 1;
  localparam int TDIV_B = 4;
`ifdef YSYX_22040750_CLINT_MSIP_EN
  localparam bit MSIP_ON = 1'b1;
`else
  localparam bit MSIP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n;
  logic        sel;
  logic        req_valid, req_wen, rsp_ready;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  int tests = 0;
  int fails = 0;

  ysyx_22040750_clint_if ifa ();
  ysyx_22040750_clint_if ifb ();

  assign ifa.req_valid = req_valid & ~sel;
  assign ifa.req_wen   = req_wen;
  assign ifa.req_addr  = req_addr;
  assign ifa.req_wdata = req_wdata;
  assign ifa.req_wstrb = req_wstrb;
  assign ifa.rsp_ready = rsp_ready & ~sel;
  assign ifb.req_valid = req_valid & sel;
  assign ifb.req_wen   = req_wen;
  assign ifb.req_addr  = req_addr;
  assign ifb.req_wdata = req_wdata;
  assign ifb.req_wstrb = req_wstrb;
  assign ifb.rsp_ready = rsp_ready & sel;

  logic mtip_a, mtip_b;
`ifdef YSYX_22040750_CLINT_MSIP_EN
  logic msip_a, msip_b;
`endif

  ysyx_22040750_clint #(.TICK_DIV(TDIV_A)) dut_a (
    .I_sys_clk (clk),
    .I_rst_n   (rst_n[0]),
    .bus       (ifa),
    .O_mtip    (mtip_a)
`ifdef YSYX_22040750_CLINT_MSIP_EN
    ,
    .O_msip    (msip_a)
`endif
  );

  ysyx_22040750_clint #(.TICK_DIV(TDIV_B)) dut_b (
    .I_sys_clk (clk),
    .I_rst_n   (rst_n[1]),
    .bus       (ifb),
    .O_mtip    (mtip_b)
`ifdef YSYX_22040750_CLINT_MSIP_EN
    ,
    .O_msip    (msip_b)
`endif
  );

  logic        req_ready_m, rsp_valid_m, rsp_err_m, mtip_m;
  logic [63:0] rsp_rdata_m;
  assign req_ready_m = sel ? ifb.req_ready : ifa.req_ready;
  assign rsp_valid_m = sel ? ifb.rsp_valid : ifa.rsp_valid;
  assign rsp_err_m   = sel ? ifb.rsp_err   : ifa.rsp_err;
  assign rsp_rdata_m = sel ? ifb.rsp_rdata : ifa.rsp_rdata;
  assign mtip_m      = sel ? mtip_b        : mtip_a;

  // ---------------- reference model ----------------
  logic [63:0] m_time [2];
  logic [63:0] m_cmp  [2];
  logic        m_msip [2];
  logic        m_mtip [2];
  logic        m_busy [2];
  logic [63:0] e_rdata[2];
  logic        e_err  [2];
  int          m_k    [2];

  function automatic logic [63:0] bmerge(input logic [63:0] old, input logic [63:0] nw,
                                         input logic [7:0] strb);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // 0 unmapped, 1 msip, 2 mtimecmp, 3 mtime
  function automatic int region(input logic [31:0] a);
    logic [31:0] off;
    off = {a[31:3], 3'b000} - BASE;
    if (off == 32'h4000) return 2;
    if (off == 32'hBFF8) return 3;
    if (off == 32'h0000 && MSIP_ON) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit v, rr, acc, tk;
      int rg, tdiv;
      v    = req_valid && (sel == (d == 1));
      rr   = rsp_ready && (sel == (d == 1));
      tdiv = (d == 0) ? TDIV_A : TDIV_B;
      rg   = region(req_addr);
      acc  = v && !m_busy[d];
      tk   = (m_k[d] % tdiv) == (tdiv - 1);
      if (!rst_n[d]) begin
        m_time[d] <= 64'd0;  m_cmp[d] <= '1;     m_msip[d] <= 1'b0;
        m_mtip[d] <= 1'b0;   m_busy[d] <= 1'b0;  m_k[d] <= 0;
        e_rdata[d] <= 64'd0; e_err[d] <= 1'b0;
      end else begin
        m_k[d]    <= m_k[d] + 1;
        m_mtip[d] <= (m_time[d] >= m_cmp[d]);
        if (acc && req_wen && rg == 3) m_time[d] <= bmerge(m_time[d], req_wdata, req_wstrb);
        else if (tk)                   m_time[d] <= m_time[d] + 64'd1;
        if (acc && req_wen && rg == 2) m_cmp[d] <= bmerge(m_cmp[d], req_wdata, req_wstrb);
        if (acc && req_wen && rg == 1 && req_wstrb[0]) m_msip[d] <= req_wdata[0];
        if (m_busy[d]) begin
          if (rr) m_busy[d] <= 1'b0;
        end else if (v) begin
          m_busy[d] <= 1'b1;
          e_err[d]  <= (rg == 0);
          if (req_wen || rg == 0) e_rdata[d] <= 64'd0;
          else if (rg == 3)       e_rdata[d] <= m_time[d];
          else if (rg == 2)       e_rdata[d] <= m_cmp[d];
          else                    e_rdata[d] <= {63'b0, m_msip[d]};
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction; starts and ends just after a falling edge
  task automatic txn(input logic s, input logic w, input logic [31:0] a, input logic [63:0] wd,
                     input logic [7:0] st, input int hold, input string tag,
                     output logic [63:0] rd, output logic er);
    sel = s; req_wen = w; req_addr = a; req_wdata = wd; req_wstrb = st; req_valid = 1'b1;
    chk({tag, ".req_ready"}, {63'b0, req_ready_m}, {63'b0, !m_busy[s]});
    @(negedge clk);
    req_valid = 1'b0;
    rd = rsp_rdata_m;
    er = rsp_err_m;
    chk({tag, ".rsp_valid"}, {63'b0, rsp_valid_m}, {63'b0, m_busy[s]});
    chk({tag, ".rdata"},     rsp_rdata_m,          e_rdata[s]);
    chk({tag, ".err"},       {63'b0, rsp_err_m},   {63'b0, e_err[s]});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, {63'b0, rsp_valid_m}, 64'd1);
      chk({tag, ".hold_rdata"}, rsp_rdata_m, rd);
      chk({tag, ".hold_err"},   {63'b0, rsp_err_m}, {63'b0, er});
      chk({tag, ".hold_ready"}, {63'b0, req_ready_m}, 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".done_valid"}, {63'b0, rsp_valid_m}, {63'b0, m_busy[s]});
    chk({tag, ".mtip"},       {63'b0, mtip_m},      {63'b0, m_mtip[s]});
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin : stim
    logic [63:0] rd;
    logic        er;
    int          pick;
    logic [31:0] a;

    rst_n = 2'b00; sel = 1'b0; req_valid = 1'b0; req_wen = 1'b0; rsp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(negedge clk);

    // Reset state of both instances
    chk("rst.a.req_ready", {63'b0, ifa.req_ready}, 64'd1);
    chk("rst.a.rsp_valid", {63'b0, ifa.rsp_valid}, 64'd0);
    chk("rst.a.rdata",     ifa.rsp_rdata, 64'd0);
    chk("rst.a.err",       {63'b0, ifa.rsp_err}, 64'd0);
    chk("rst.a.mtip",      {63'b0, mtip_a}, 64'd0);
    chk("rst.b.req_ready", {63'b0, ifb.req_ready}, 64'd1);
    chk("rst.b.mtip",      {63'b0, mtip_b}, 64'd0);
`ifdef YSYX_22040750_CLINT_MSIP_EN
    chk("rst.a.msip",      {63'b0, msip_a}, 64'd0);
`endif

    rst_n = 2'b11;
    repeat (10) @(negedge clk);

    // mtime after 10 idle clocks
    txn(1'b0, 1'b0, A_MTIME, 64'd0, 8'h00, 0, "rd_mtime10", rd, er);
    chk("rd_mtime10.value", rd, 64'd10);
    chk("rd_mtime10.noerr", {63'b0, er}, 64'd0);

    // mtimecmp = 20: follow O_mtip through the crossing
    txn(1'b0, 1'b1, A_CMP, 64'd20, 8'hFF, 0, "wr_cmp20", rd, er);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("mtip_track", {63'b0, mtip_a}, {63'b0, m_mtip[0]});
    end
    chk("mtip_raised", {63'b0, mtip_a}, 64'd1);

    // raising mtimecmp clears the level
    txn(1'b0, 1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, "wr_cmp_max", rd, er);
    repeat (2) @(negedge clk);
    chk("mtip_cleared", {63'b0, mtip_a}, 64'd0);

    // mtime wrap-around
    txn(1'b0, 1'b1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, "wr_mtime_wrap", rd, er);
    repeat (2) @(negedge clk);
    txn(1'b0, 1'b0, A_MTIME, 64'd0, 8'h00, 0, "rd_wrap", rd, er);
    chk("rd_wrap.value", rd, 64'd1);
    chk("rd_wrap.noerr", {63'b0, er}, 64'd0);

    // partial byte write to mtimecmp
    txn(1'b0, 1'b1, A_CMP, 64'h0000_0000_DEAD_BEEF, 8'h0F, 0, "wr_cmp_lo", rd, er);
    txn(1'b0, 1'b0, A_CMP, 64'd0, 8'h00, 1, "rd_cmp_lo", rd, er);
    chk("rd_cmp_lo.value", rd, 64'hFFFF_FFFF_DEAD_BEEF);

    // unmapped read with a stalled consumer
    txn(1'b0, 1'b0, BASE + 32'h1000, 64'd0, 8'h00, 5, "rd_unmapped", rd, er);
    chk("rd_unmapped.err",   {63'b0, er}, 64'd1);
    chk("rd_unmapped.rdata", rd, 64'd0);

    // msip slot
    txn(1'b0, 1'b1, A_MSIP, 64'd1, 8'h01, 0, "wr_msip", rd, er);
    chk("wr_msip.err", {63'b0, er}, {63'b0, !MSIP_ON});
`ifdef YSYX_22040750_CLINT_MSIP_EN
    chk("msip_out", {63'b0, msip_a}, 64'd1);
    txn(1'b0, 1'b0, A_MSIP, 64'd0, 8'h00, 0, "rd_msip", rd, er);
    chk("rd_msip.value", rd, 64'd1);
`endif

    // randomized traffic on instance A
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 3);
      case (pick)
        0:       a = A_CMP;
        1:       a = A_MTIME;
        2:       a = A_MSIP;
        default: a = BASE + 32'h8000 + ($urandom_range(0, 255) << 3);
      endcase
      a = a | 32'($urandom_range(0, 7));
      txn(1'b0, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom),
          $urandom_range(0, 2), "rand", rd, er);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // instance B: reset in the middle of a response
    sel = 1'b1; req_wen = 1'b0; req_addr = A_MTIME; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("b.resp_pending", {63'b0, ifb.rsp_valid}, {63'b0, m_busy[1]});
    rst_n[1] = 1'b0;
    @(negedge clk);
    chk("b.rst_rsp_valid", {63'b0, ifb.rsp_valid}, 64'd0);
    chk("b.rst_req_ready", {63'b0, ifb.req_ready}, 64'd1);
    chk("b.rst_rdata",     ifb.rsp_rdata, 64'd0);
    chk("b.rst_mtip",      {63'b0, mtip_b}, 64'd0);
    rst_n[1] = 1'b1;
    @(negedge clk);
    txn(1'b1, 1'b0, A_MTIME, 64'd0, 8'h00, 0, "b.rd_mtime0", rd, er);
    chk("b.rd_mtime0.value", rd, 64'd0);

    // instance B: mtime advances once per 4 clocks
    repeat (13) @(negedge clk);
    txn(1'b1, 1'b0, A_MTIME, 64'd0, 8'h00, 0, "b.rd_mtime4", rd, er);
    chk("b.rd_mtime4.value", rd, 64'd4);
    txn(1'b1, 1'b1, A_MSIP, 64'd1, 8'h01, 0, "b.wr_msip", rd, er);
    chk("b.wr_msip.err", {63'b0, er}, {63'b0, !MSIP_ON});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
